// File: rtl/axis_iter_divider.sv
// axis_iter_divider: multi-cycle radix-2 restoring integer divider.
// Dividend and divisor arrive on two independent AXI-Stream slave channels.
// One quotient bit is produced per cycle. {quotient, remainder} is returned
// as a one-cycle strobe with no back-pressure.
// Optional build macro: DIV_ZERO_BYPASS_EN. With it, a zero divisor skips
// the iterations and answers in the cycle after the last operand handshake.
//
// Handshake rules:
//   - An input transfer occurs on a rising clk edge where tvalid and tready
//     are both high.
//   - tready depends only on internal state, never on tvalid, so a source
//     may hold tvalid high across CALC; it is simply ignored there.
//   - The output channel has no tready. m_axis_dout_tvalid is high for
//     exactly one cycle per result, and m_axis_dout_tdata holds its value
//     until the next result.
module axis_iter_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid,
    output logic                 o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operand capture registers and their held flags.
    logic               r_have_dvd;
    logic               r_have_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;

    // Iteration state.
    // r_quo starts as the dividend magnitude. Dividend bits shift out of its
    // MSB while quotient bits shift in at its LSB.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_den;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [CW-1:0]      r_count;

    logic [2*WIDTH-1:0] r_dout;
    logic               r_dout_valid;

    logic               w_dvd_fire;
    logic               w_dvs_fire;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_start;
    logic               w_bypass;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    assign s_axis_dividend_tready = (r_state == ST_IDLE) && !r_have_dvd;
    assign s_axis_divisor_tready  = (r_state == ST_IDLE) && !r_have_dvs;
    assign m_axis_dout_tdata      = r_dout;
    assign m_axis_dout_tvalid     = r_dout_valid;
    assign o_dbg_state            = (r_state == ST_CALC);

    assign w_dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign w_dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;

    // Operands as seen at the start edge: either held or arriving right now.
    assign w_a = r_have_dvd ? r_dvd : s_axis_dividend_tdata;
    assign w_b = r_have_dvs ? r_dvs : s_axis_divisor_tdata;

    assign w_a_neg = SIGNED && w_a[WIDTH-1];
    assign w_b_neg = SIGNED && w_b[WIDTH-1];
    // Magnitudes are unsigned WIDTH-bit values, so the most negative
    // operand maps onto itself (1000...0).
    assign w_a_mag = w_a_neg ? -w_a : w_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    assign w_start = (r_state == ST_IDLE)
                  && (r_have_dvd || w_dvd_fire)
                  && (r_have_dvs || w_dvs_fire);

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = w_start && (w_b_mag == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_last = (r_state == ST_CALC) && (r_count == LAST);

    // One restoring step.
    // The partial remainder stays below the divisor, or below 2^k after k
    // steps when the divisor is zero. So a non-negative difference always
    // fits in WIDTH bits, and the top bit of w_diff is the borrow.
    assign w_shift    = {1'b0, r_rem} << 1 | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_den};
    assign w_ge       = !w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_q_final  = r_q_neg ? -w_quo_next : w_quo_next;
    assign w_r_final  = r_r_neg ? -w_rem_next : w_rem_next;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start when both operands are present; finish on the last bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start && !w_bypass) w_state_next = ST_CALC;
            ST_CALC: if (w_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_have_dvd   <= 1'b0;
            r_have_dvs   <= 1'b0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_den        <= '0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_dvd_fire) begin
                    r_dvd      <= s_axis_dividend_tdata;
                    r_have_dvd <= 1'b1;
                end
                if (w_dvs_fire) begin
                    r_dvs      <= s_axis_divisor_tdata;
                    r_have_dvs <= 1'b1;
                end
                if (w_start) begin
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
                    r_den   <= w_b_mag;
                    r_count <= '0;
                    if (w_bypass) begin
                        // Same values the iterative path would give:
                        // Q = all ones before the sign is applied, R = dividend.
                        r_dout       <= {(w_a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}}), w_a};
                        r_dout_valid <= 1'b1;
                        r_have_dvd   <= 1'b0;
                        r_have_dvs   <= 1'b0;
                    end
                end
            end else begin
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_dout       <= {w_q_final, w_r_final};
                    r_dout_valid <= 1'b1;
                    r_have_dvd   <= 1'b0;
                    r_have_dvs   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_iter_divider.sv
// Bench for axis_iter_divider.
// An unsigned and a signed instance share the same stimulus. Each request
// is checked on both instances against a plain-arithmetic reference. Result
// timing and tready behaviour are checked cycle by cycle.
module tb_axis_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dvd_data;
    logic        dvd_valid;
    logic [31:0] dvs_data;
    logic        dvs_valid;

    logic        dvd_rdy_u, dvs_rdy_u, tvalid_u, dbg_u;
    logic        dvd_rdy_s, dvs_rdy_s, tvalid_s, dbg_s;
    logic [63:0] dout_u, dout_s;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q_u[$];
    logic [63:0] exp_q_s[$];
    int          exp_cyc_u[$];
    int          exp_cyc_s[$];

    // Bench-side model of when tready must be low.
    int calc_lo = 1;
    int calc_hi = 0;
    bit held_dvd = 0;
    bit held_dvs = 0;

    axis_iter_divider #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .reset(reset),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(dvd_rdy_u),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
        .s_axis_divisor_tready(dvs_rdy_u),
        .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(tvalid_u),
        .o_dbg_state(dbg_u)
    );

    axis_iter_divider #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset(reset),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(dvd_rdy_s),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
        .s_axis_divisor_tready(dvs_rdy_s),
        .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(tvalid_s),
        .o_dbg_state(dbg_s)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: truncating division, remainder takes the dividend's
    // sign, divide-by-zero gives Q = -1 (or +1 for a negative dividend) and
    // R = dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] q;
        logic [31:0] r;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sgn) begin
            if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
            else begin q = a / b; r = a % b; end
        end else begin
            if (b == 0) begin q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF; r = a; end
            else begin q = 32'(sa / sb); r = 32'(sa % sb); end
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic check_ready();
        bit busy;
        busy = (cyc >= calc_lo) && (cyc <= calc_hi);
        check("dividend_tready_u", 64'(dvd_rdy_u), 64'(!busy && !held_dvd));
        check("divisor_tready_u",  64'(dvs_rdy_u), 64'(!busy && !held_dvs));
        check("dividend_tready_s", 64'(dvd_rdy_s), 64'(!busy && !held_dvd));
        check("divisor_tready_s",  64'(dvs_rdy_s), 64'(!busy && !held_dvs));
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            dvd_valid = 1'b0;
            dvs_valid = 1'b0;
            dvd_data  = $urandom();
            dvs_data  = $urandom();
            check_ready();
        end
    endtask

    // Offer both operands, each after its own delay. Returns at the negedge
    // of the cycle in which the last operand handshakes.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int d_dvd, input int d_dvs);
        bit dvd_done;
        bit dvs_done;
        bit byp;
        int t;
        int n;
        dvd_done = 0;
        dvs_done = 0;
        t = 0;
        byp = 0;
`ifdef DIV_ZERO_BYPASS_EN
        byp = (b == 0);
`endif
        while (!(dvd_done && dvs_done)) begin
            @(negedge clk);
            dvd_valid = !dvd_done && (t >= d_dvd);
            dvd_data  = dvd_valid ? a : $urandom();
            dvs_valid = !dvs_done && (t >= d_dvs);
            dvs_data  = dvs_valid ? b : $urandom();
            check_ready();
            if (dvd_valid && dvd_rdy_u) begin dvd_done = 1; held_dvd = 1; end
            if (dvs_valid && dvs_rdy_u) begin dvs_done = 1; held_dvs = 1; end
            if (dvd_done && dvs_done) begin
                n = cyc;
                held_dvd = 0;
                held_dvs = 0;
                exp_q_u.push_back(ref_div(a, b, 1'b0));
                exp_q_s.push_back(ref_div(a, b, 1'b1));
                if (byp) begin
                    exp_cyc_u.push_back(n + 1);
                    exp_cyc_s.push_back(n + 1);
                end else begin
                    calc_lo = n + 1;
                    calc_hi = n + 32;
                    exp_cyc_u.push_back(n + 33);
                    exp_cyc_s.push_back(n + 33);
                end
            end
            t++;
            if (t > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL issue_timeout: operands not accepted after %0d cycles", t);
                break;
            end
        end
    endtask

    task automatic dividend_only(input logic [31:0] a);
        @(negedge clk);
        dvd_valid = 1'b1;
        dvd_data  = a;
        dvs_valid = 1'b0;
        dvs_data  = $urandom();
        check_ready();
        if (dvd_rdy_u) held_dvd = 1;
    endtask

    // One-cycle synchronous reset pulse; anything still in flight is lost.
    task automatic pulse_reset();
        int c;
        @(negedge clk);
        reset     = 1'b1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        check_ready();
        c = cyc;
        if (calc_hi > c) calc_hi = c;
        if (exp_cyc_u.size() > 0 && exp_cyc_u[$] > c) begin
            void'(exp_q_u.pop_back());
            void'(exp_cyc_u.pop_back());
        end
        if (exp_cyc_s.size() > 0 && exp_cyc_s[$] > c) begin
            void'(exp_q_s.pop_back());
            void'(exp_cyc_s.pop_back());
        end
        held_dvd = 0;
        held_dvs = 0;
        @(negedge clk);
        reset = 1'b0;
        check_ready();
        check("post_reset_tvalid_u", 64'(tvalid_u), 64'd0);
        check("post_reset_tdata_u",  dout_u, 64'd0);
        check("post_reset_tvalid_s", 64'(tvalid_s), 64'd0);
        check("post_reset_tdata_s",  dout_s, 64'd0);
    endtask

    // Monitor: every strobe must match the head of the expected queue,
    // both in value and in the cycle it appears.
    logic prev_u = 1'b0;
    logic prev_s = 1'b0;
    always @(negedge clk) begin
        if (tvalid_u === 1'b1) begin
            if (exp_q_u.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe_u: got %h expected no result (cycle %0d)", dout_u, cyc);
            end else begin
                check("result_u", dout_u, exp_q_u.pop_front());
                check("strobe_cycle_u", 64'(cyc), 64'(exp_cyc_u.pop_front()));
            end
`ifndef DIV_ZERO_BYPASS_EN
            check("strobe_gap_u", 64'(prev_u), 64'd0);
`endif
        end
        if (tvalid_s === 1'b1) begin
            if (exp_q_s.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe_s: got %h expected no result (cycle %0d)", dout_s, cyc);
            end else begin
                check("result_s", dout_s, exp_q_s.pop_front());
                check("strobe_cycle_s", 64'(cyc), 64'(exp_cyc_s.pop_front()));
            end
`ifndef DIV_ZERO_BYPASS_EN
            check("strobe_gap_s", 64'(prev_s), 64'd0);
`endif
        end
        prev_u = (tvalid_u === 1'b1);
        prev_s = (tvalid_s === 1'b1);
    end

    // Main sequence: reset values, directed cases, reset recovery, random.
    initial begin
        reset     = 1'b1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = '0;
        dvs_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_tvalid_u", 64'(tvalid_u), 64'd0);
        check("reset_tdata_u",  dout_u, 64'd0);
        check("reset_tvalid_s", 64'(tvalid_s), 64'd0);
        check("reset_tdata_s",  dout_s, 64'd0);
        check("reset_state_u",  64'(dbg_u), 64'd0);
        check("reset_state_s",  64'(dbg_s), 64'd0);
        check_ready();
        reset = 1'b0;
        idle(2);

        issue(32'd100, 32'd7, 0, 0);
        idle(36);
        issue(-32'sd7, 32'd2, 0, 3);
        idle(38);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        issue(32'd7, -32'sd2, 0, 0);
        issue(32'd5, 32'd0, 0, 0);
        issue(-32'sd5, 32'd0, 2, 0);
        issue(32'd1000, 32'd10, 0, 0);
        issue(32'd99, 32'd100, 0, 0);
        idle(36);

        issue(32'd123456, 32'd789, 0, 0);
        idle(9);
        pulse_reset();
        idle(30);
        issue(32'd9, 32'd3, 0, 0);
        idle(36);

        dividend_only(32'd77);
        pulse_reset();
        issue(32'd9, 32'd3, 1, 0);
        idle(36);

        repeat (40) begin
            issue(rand_op(), rand_op(), $urandom_range(0, 4), $urandom_range(0, 4));
        end
        idle(40);

        check("pending_results_u", 64'(exp_q_u.size()), 64'd0);
        check("pending_results_s", 64'(exp_q_s.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
